// File: rtl/core_pkg.sv
// Shared types for the decode-centred hazard unit: forwarding selects,
// sequencer states and the shadow-pipeline entry.
package core_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              isload;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } shadow_t;

    // x0 is hard-wired, so an entry targeting it never produces a value.
    function automatic logic is_writer(shadow_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB.
module fwd_sel
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] rs_i,
    input  shadow_t           m_i,
    input  shadow_t           w_i,
    output fwd_sel_e          sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (is_writer(m_i) && (m_i.rd == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (is_writer(w_i) && (w_i.rd == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: shadow EX/MEM/WB tracking, load-use stall FSM,
// redirect flushes and EX forwarding selects.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int REGW     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validD,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rdD,
    input  logic            regwriteD,
    input  logic            resultsrcD,
    input  logic            pcsrcE,
    output logic            stallF,
    output logic            stallD,
    output logic            flushD,
    output logic            flushE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            busy
);

    localparam int          CNT_I    = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
    localparam logic [1:0]  CNT_INIT = 2'(CNT_I);

    hz_state_e  state_q;
    logic [1:0] cnt_q;
    shadow_t    e_q, m_q, w_q;
    shadow_t    e_d;
    fwd_sel_e   fa, fb;
    logic       load_use, stall_req;

    assign load_use = is_writer(e_q) & e_q.isload & validD &
                      ((e_q.rd == rs1D) | (e_q.rd == rs2D));

    assign stall_req = (state_q == LDSTALL) | load_use;

    // Redirect wins: the stalled consumer is on the wrong path anyway.
    always_comb begin
        stallF    = ~rst & stall_req & ~pcsrcE;
        stallD    = ~rst & stall_req & ~pcsrcE;
        flushD    = ~rst & pcsrcE;
        flushE    = ~rst & (stall_req | pcsrcE);
        busy      = ~rst & (state_q == LDSTALL);
        forwardAE = rst ? 2'b00 : fa;
        forwardBE = rst ? 2'b00 : fb;
    end

    fwd_sel u_fwd_a (
        .rs_i  (e_q.rs1),
        .m_i   (m_q),
        .w_i   (w_q),
        .sel_o (fa)
    );

    fwd_sel u_fwd_b (
        .rs_i  (e_q.rs2),
        .m_i   (m_q),
        .w_i   (w_q),
        .sel_o (fb)
    );

    always_comb begin
        e_d = e_q;
        if (flushE) begin
            e_d = '0;
        end else if (!stallD) begin
            e_d.valid    = validD;
            e_d.rd       = rdD;
            e_d.regwrite = regwriteD;
            e_d.isload   = resultsrcD;
            e_d.rs1      = rs1D;
            e_d.rs2      = rs2D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (pcsrcE) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use && (LOAD_LAT > 1)) begin
                        state_q <= LDSTALL;
                        cnt_q   <= CNT_INIT;
                    end
                end
                LDSTALL: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: one LOAD_LAT=1 and one LOAD_LAT=3 instance on shared inputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       validD;
    logic [4:0] rs1D, rs2D, rdD;
    logic       regwriteD, resultsrcD, pcsrcE;

    logic       sF1, sD1, fD1, fE1, b1;
    logic [1:0] fA1, fB1;
    logic       sF3, sD3, fD3, fE3, b3;
    logic [1:0] fA3, fB3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .REGW(5)) dut1 (
        .clk(clk), .rst(rst), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .regwriteD(regwriteD), .resultsrcD(resultsrcD),
        .pcsrcE(pcsrcE),
        .stallF(sF1), .stallD(sD1), .flushD(fD1), .flushE(fE1),
        .forwardAE(fA1), .forwardBE(fB1), .busy(b1)
    );

    hazard_ctrl #(.LOAD_LAT(3), .REGW(5)) dut3 (
        .clk(clk), .rst(rst), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .regwriteD(regwriteD), .resultsrcD(resultsrcD),
        .pcsrcE(pcsrcE),
        .stallF(sF3), .stallD(sD3), .flushD(fD3), .flushE(fE3),
        .forwardAE(fA3), .forwardBE(fB3), .busy(b3)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic v, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d,
                        input logic rw, input logic ld);
        validD = v; rs1D = a; rs2D = b; rdD = d;
        regwriteD = rw; resultsrcD = ld;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        pcsrcE = 1'b0;
        setD(0, 0, 0, 0, 0, 0);
        tick;
        rst = 1'b0;
    endtask

    // {stallF, stallD, flushD, flushE, busy}
    function automatic logic [7:0] ctl1();
        return {3'b0, sF1, sD1, fD1, fE1, b1};
    endfunction
    function automatic logic [7:0] ctl3();
        return {3'b0, sF3, sD3, fD3, fE3, b3};
    endfunction
    function automatic logic [7:0] fw1();
        return {4'b0, fA1, fB1};
    endfunction
    function automatic logic [7:0] fw3();
        return {4'b0, fA3, fB3};
    endfunction

    initial begin
        rst = 1'b1;
        pcsrcE = 1'b0;
        setD(0, 0, 0, 0, 0, 0);
        tick;
        chk("reset_ctl1", ctl1(), 8'h00);
        chk("reset_fw1", fw1(), 8'h00);
        chk("reset_ctl3", ctl3(), 8'h00);
        rst = 1'b0;

        // RAW without load: back-to-back then one apart
        setD(1, 1, 2, 5, 1, 0);
        tick;
        setD(1, 5, 1, 6, 1, 0);
        chk("raw_nostall", ctl1(), 8'h00);
        tick;
        setD(1, 1, 2, 9, 1, 0);
        chk("raw_mem_fwd", fw1(), {4'b0, 2'b10, 2'b00});
        chk("raw_nostall2", ctl1(), 8'h00);
        tick;
        setD(1, 1, 2, 11, 1, 0);
        tick;
        setD(1, 1, 9, 10, 1, 0);
        tick;
        setD(0, 0, 0, 0, 0, 0);
        chk("raw_wb_fwd", fw1(), {4'b0, 2'b00, 2'b01});

        // load-use, LOAD_LAT=1
        do_reset;
        setD(1, 1, 0, 7, 1, 1);
        tick;
        setD(1, 7, 7, 8, 1, 0);
        chk("lu1_stall", ctl1(), 8'b11010);
        tick;
        chk("lu1_release", ctl1(), 8'h00);
        tick;
        setD(0, 0, 0, 0, 0, 0);
        chk("lu1_fwd", fw1(), {4'b0, 2'b01, 2'b01});

        // load-use, LOAD_LAT=3
        do_reset;
        setD(1, 1, 0, 7, 1, 1);
        tick;
        setD(1, 7, 7, 8, 1, 0);
        chk("lu3_c1", ctl3(), 8'b11010);
        tick;
        chk("lu3_c2", ctl3(), 8'b11011);
        tick;
        chk("lu3_c3", ctl3(), 8'b11011);
        tick;
        chk("lu3_run", ctl3(), 8'h00);

        // x0 destination never hazards or forwards
        do_reset;
        setD(1, 1, 0, 0, 1, 1);
        tick;
        setD(1, 0, 0, 1, 1, 0);
        chk("x0_nostall1", ctl1(), 8'h00);
        chk("x0_nostall3", ctl3(), 8'h00);
        tick;
        setD(0, 0, 0, 0, 0, 0);
        chk("x0_fwd", fw1(), 8'h00);

        // redirect on the load-use detect cycle
        do_reset;
        setD(1, 1, 0, 7, 1, 1);
        tick;
        pcsrcE = 1'b1;
        setD(1, 7, 7, 8, 1, 0);
        chk("rd_lu3", ctl3(), 8'b00110);
        chk("rd_lu1", ctl1(), 8'b00110);
        tick;
        pcsrcE = 1'b0;
        setD(0, 0, 0, 0, 0, 0);
        chk("rd_lu_after", ctl3(), 8'h00);

        // redirect in cycle 2 of a LOAD_LAT=3 stall
        do_reset;
        setD(1, 1, 0, 7, 1, 1);
        tick;
        setD(1, 7, 7, 8, 1, 0);
        chk("rd_ld_c1", ctl3(), 8'b11010);
        tick;
        pcsrcE = 1'b1;
        setD(1, 7, 7, 8, 1, 0);
        chk("rd_ld_c2", ctl3(), 8'b00111);
        tick;
        pcsrcE = 1'b0;
        setD(0, 0, 0, 0, 0, 0);
        chk("rd_ld_after", ctl3(), 8'h00);

        // reset in the middle of LDSTALL
        do_reset;
        setD(1, 1, 0, 7, 1, 1);
        tick;
        setD(1, 7, 7, 8, 1, 0);
        tick;
        chk("rst_mid_busy", ctl3(), 8'b11011);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", ctl3(), 8'h00);
        chk("rst_mid_fw", fw3(), 8'h00);
        tick;
        rst = 1'b0;
        setD(1, 7, 8, 9, 1, 0);
        chk("rst_after_ctl", ctl3(), 8'h00);
        tick;
        setD(0, 0, 0, 0, 0, 0);
        chk("rst_after_fw", fw3(), 8'h00);
        chk("rst_after_ctl2", ctl3(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
